// File: rtl/bias_add_stream.sv
// Bias adder on the adder-tree output: per-lane bias add, saturation, valid/ready stream, frame pixel counter.
// Build macro BIAS_ADD_RELU_EN: when defined, negative lane results are clamped to zero after saturation.
module bias_add_stream #(
  parameter int N_ADDER_TREE = 16,
  parameter int DATA_W       = 18,
  parameter int NUM_PIXELS   = 60,
  parameter int CNT_W        = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_ADDER_TREE*DATA_W-1:0]   bias,
  input  logic [N_ADDER_TREE*DATA_W-1:0]   in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [N_ADDER_TREE*DATA_W-1:0]   out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [CNT_W-1:0]                 pixel_cnt,
  output logic                             frame_done
);
  localparam int BUS_W = N_ADDER_TREE * DATA_W;
  localparam int SUM_W = DATA_W + 1;
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(NUM_PIXELS - 1);

  function automatic logic signed [SUM_W-1:0] add_lane(input logic signed [DATA_W-1:0] a,
                                                       input logic signed [DATA_W-1:0] b);
    add_lane = $signed({a[DATA_W-1], a}) + $signed({b[DATA_W-1], b});
  endfunction

  // One guard bit: overflow shows as the two top bits disagreeing.
  function automatic logic signed [DATA_W-1:0] sat_lane(input logic signed [SUM_W-1:0] s);
    if (s[SUM_W-1] != s[SUM_W-2])
      sat_lane = s[SUM_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    else
      sat_lane = s[DATA_W-1:0];
  endfunction

  function automatic logic signed [DATA_W-1:0] lane_out(input logic signed [SUM_W-1:0] s);
    logic signed [DATA_W-1:0] v;
    v = sat_lane(s);
`ifdef BIAS_ADD_RELU_EN
    if (v[DATA_W-1]) v = '0;
`endif
    lane_out = v;
  endfunction

  logic                    en;
  logic                    vld_p1_q;
  logic signed [SUM_W-1:0] sum_p1_d [N_ADDER_TREE];
  logic signed [SUM_W-1:0] sum_p1_q [N_ADDER_TREE];
  logic                    vld_p2_q;
  logic [BUS_W-1:0]        data_p2_d;
  logic [BUS_W-1:0]        data_p2_q;
  logic [CNT_W-1:0]        cnt_d, cnt_q;
  logic                    done_d, done_q;

  assign en         = ~vld_p2_q | out_ready;
  assign in_ready   = en;
  assign out_valid  = vld_p2_q;
  assign out_data   = data_p2_q;
  assign pixel_cnt  = cnt_q;
  assign frame_done = done_q;

  // Stage 1: exact lane-wise bias add
  always_comb begin
    for (int i = 0; i < N_ADDER_TREE; i++)
      sum_p1_d[i] = add_lane(in_data[i*DATA_W +: DATA_W], bias[i*DATA_W +: DATA_W]);
  end

  // Stage 2: saturate (and optional ReLU) back to DATA_W
  always_comb begin
    data_p2_d = '0;
    for (int i = 0; i < N_ADDER_TREE; i++)
      data_p2_d[i*DATA_W +: DATA_W] = lane_out(sum_p1_q[i]);
  end

  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (vld_p2_q && out_ready) begin
      if (cnt_q == LAST_PIX) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      data_p2_q <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      for (int i = 0; i < N_ADDER_TREE; i++)
        sum_p1_q[i] <= '0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
      if (en) begin
        vld_p1_q <= in_valid;
        sum_p1_q <= sum_p1_d;
        vld_p2_q <= vld_p1_q;
        if (vld_p1_q) data_p2_q <= data_p2_d;
      end
    end
  end

endmodule

// File: tb/tb_bias_add_stream.sv
// Self-checking bench for bias_add_stream: directed cases plus randomized streaming against a queue-based model.
module tb_bias_add_stream;
  localparam int N    = 16;
  localparam int DW   = 18;
  localparam int NP   = 60;
  localparam int CW   = 16;
  localparam int W    = N * DW;
  localparam int MAXV = (1 << (DW - 1)) - 1;
  localparam int MINV = -(1 << (DW - 1));
`ifdef BIAS_ADD_RELU_EN
  localparam int RELU = 1;
`else
  localparam int RELU = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [W-1:0]  bias;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] pixel_cnt;
  logic          frame_done;

  int n_tests = 0;
  int n_fail  = 0;
  int ready_mode = 0;

  logic [W-1:0] exp_q[$];
  int           done_at[$];
  int           mcnt = 0;
  int           mdone = 0;
  int           ohs = 0;
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data = '0;

  bias_add_stream #(.N_ADDER_TREE(N), .DATA_W(DW), .NUM_PIXELS(NP), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .bias(bias), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .pixel_cnt(pixel_cnt), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_vec(input logic [W-1:0] d, input logic [W-1:0] b);
    logic [W-1:0] r = '0;
    for (int i = 0; i < N; i++) begin
      logic signed [DW-1:0] x;
      logic signed [DW-1:0] y;
      int s;
      x = d[i*DW +: DW];
      y = b[i*DW +: DW];
      s = int'(x) + int'(y);
      if (s > MAXV) s = MAXV;
      else if (s < MINV) s = MINV;
      if (RELU != 0 && s < 0) s = 0;
      r[i*DW +: DW] = s[DW-1:0];
    end
    return r;
  endfunction

  function automatic logic [W-1:0] put(input logic [W-1:0] v, input int i, input int x);
    logic [W-1:0] r = v;
    int t = x;
    r[i*DW +: DW] = t[DW-1:0];
    return r;
  endfunction

  function automatic logic [W-1:0] fill(input int x);
    logic [W-1:0] r = '0;
    for (int i = 0; i < N; i++) r = put(r, i, x);
    return r;
  endfunction

  function automatic logic [W-1:0] rnd_vec();
    logic [W-1:0] r = '0;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = DW'($urandom);
    return r;
  endfunction

  // Scoreboard: handshakes sampled mid-cycle, ahead of the edge that consumes them.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      mcnt = 0; mdone = 0; ohs = 0; prev_stall = 1'b0;
    end else begin
      check("pixel_cnt", W'(pixel_cnt), W'(mcnt));
      check("frame_done", W'(frame_done), W'(mdone));
      if (frame_done) begin
        done_at.push_back(ohs);
        check("cnt_after_done", W'(pixel_cnt), W'(0));
      end
      check("in_ready", W'(in_ready), W'(!out_valid || out_ready));
      if (prev_stall) begin
        check("hold_valid", W'(out_valid), W'(1));
        check("hold_data", out_data, prev_data);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      mdone = 0;
      if (in_valid && in_ready) exp_q.push_back(ref_vec(in_data, bias));
      if (out_valid && out_ready) begin
        ohs++;
        check("out_avail", W'(exp_q.size() > 0), W'(1));
        if (exp_q.size() > 0) check("out_data", out_data, exp_q.pop_front());
        if (mcnt == NP - 1) begin mcnt = 0; mdone = 1; end
        else mcnt++;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic send(input logic [W-1:0] v);
    logic hs = 1'b0;
    in_data  = v;
    in_valid = 1'b1;
    for (int k = 0; k < 200 && !hs; k++) begin
      @(negedge clk); hs = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("send_accepted", W'(hs), W'(1));
  endtask

  task automatic wait_drain(input int maxc);
    int k = 0;
    while (exp_q.size() != 0 && k < maxc) begin
      @(negedge clk); k++;
    end
    check("drain", W'(exp_q.size()), W'(0));
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] b, e, svec[8];
    logic hs;
    int base;
    in_valid = 1'b0; in_data = '0; bias = '0; out_ready = 1'b0; ready_mode = 2;
    #3 rst = 1'b1;
    #1;
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_out_data", out_data, W'(0));
    check("rst_pixel_cnt", W'(pixel_cnt), W'(0));
    check("rst_frame_done", W'(frame_done), W'(0));
    check("rst_in_ready", W'(in_ready), W'(1));
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    ready_mode = 0; out_ready = 1'b1;
    @(posedge clk); #1;

    // Basic bias add and 2-cycle latency
    b = '0; b = put(b, 0, 8000); b = put(b, 7, -250); bias = b;
    send(fill(100));
    @(negedge clk); check("lat1_valid", W'(out_valid), W'(0));
    @(negedge clk); check("lat2_valid", W'(out_valid), W'(1));
    e = fill(100); e = put(e, 0, 8100); e = put(e, 7, RELU != 0 ? 0 : -150);
    check("basic_data", out_data, e);

    // Saturation on both rails, neighbours untouched
    e = fill(5); e = put(e, 0, 130000); e = put(e, 7, -131000);
    send(e);
    @(negedge clk); @(negedge clk);
    check("sat_valid", W'(out_valid), W'(1));
    e = fill(5); e = put(e, 0, 131071); e = put(e, 7, RELU != 0 ? 0 : -131072);
    check("sat_data", out_data, e);
    wait_drain(50);

    // Backpressure: 5 stalled cycles then full-rate drain
    for (int k = 0; k < 8; k++) svec[k] = rnd_vec();
    ready_mode = 2; out_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 8; k++) send(svec[k]);
      end
      begin
        for (int k = 0; k < 50 && !out_valid; k++) @(negedge clk);
        repeat (5) begin
          @(negedge clk);
          check("stall_in_ready", W'(in_ready), W'(0));
          check("stall_valid", W'(out_valid), W'(1));
          check("stall_data", out_data, ref_vec(svec[0], bias));
        end
        ready_mode = 0; out_ready = 1'b1;
        repeat (7) begin
          @(negedge clk);
          check("rate_valid", W'(out_valid), W'(1));
        end
      end
    join
    wait_drain(50);

    // Frame boundaries over two frames
    rst = 1'b1; @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;
    done_at.delete();
    for (int k = 0; k < 2 * NP; k++) send(rnd_vec());
    wait_drain(50);
    check("done_count", W'(done_at.size()), W'(2));
    if (done_at.size() == 2) begin
      check("done_pos0", W'(done_at[0]), W'(NP));
      check("done_pos1", W'(done_at[1]), W'(2 * NP));
    end

    // Asynchronous reset mid-frame with vectors in flight
    in_valid = 1'b1; in_data = rnd_vec();
    for (int k = 0; k < 200 && pixel_cnt != CW'(37); k++) begin
      @(negedge clk); hs = in_ready;
      @(posedge clk); #1;
      if (hs) in_data = rnd_vec();
    end
    check("pre_rst_cnt", W'(pixel_cnt), W'(37));
    check("pre_rst_valid", W'(out_valid), W'(1));
    #2;
    ready_mode = 2; out_ready = 1'b0; rst = 1'b1;
    #1;
    check("arst_out_valid", W'(out_valid), W'(0));
    check("arst_pixel_cnt", W'(pixel_cnt), W'(0));
    check("arst_in_ready", W'(in_ready), W'(1));
    in_valid = 1'b0;
    @(posedge clk); #2 rst = 1'b0;
    ready_mode = 0; out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("post_rst_valid", W'(out_valid), W'(0));
    end

    // Randomized traffic with random backpressure and new bias
    @(posedge clk); #1;
    bias = rnd_vec();
    ready_mode = 1;
    base = ohs;
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      send(rnd_vec());
    end
    wait_drain(2000);
    check("rand_out_count", W'(ohs - base), W'(200));
    ready_mode = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
